team_wb_gpio_bridge: RTL and testbench
======================================

Name: team_wb_gpio_bridge

Overview:
- Parametrised Wishbone-slave GPIO controller.
- Sits between the Caravel management Wishbone bus and a team's breakout GPIO pins, inside a team wrapper.
- Provides software-controlled output data, active-low output enables, synchronised input sampling, per-pin rising/falling edge interrupts with sticky W1C status, and hard-reserved pins.
- Successor to the fixed wrapper-level GPIO tie-offs. Pin count, base address and reserved-pin mask are now parameters.

Parameters:
- NUM_GPIO, 38, number of GPIO pins managed (1..64).
- BASE_ADDR, 32'h3000_0000, Wishbone base address. Decode window is 64 bytes; adr[31:6] must equal BASE_ADDR[31:6].
- RESERVED_MASK, 64'h1E, pins forced to input (oeb=1, out=0). Default reserves pins 4:1.
- ID_VALUE, 32'h0000_0707, read-only value of the ID register.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte-lane select
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- gpio_in  in  NUM_GPIO  pad inputs (asynchronous)
- gpio_out  out  NUM_GPIO  pad output data
- gpio_oeb  out  NUM_GPIO  pad output enable, active low
- irq  out  1  level interrupt

Behaviour:
- Reset (sync, wb_rst_i=1 at clock edge):
  - OUT=0, OEB=all 1, RISE_EN=0, FALL_EN=0, STAT=0.
  - Synchroniser and prev-sample flops = 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0.
  - Reset mid-transaction drops any pending ack; no write commits on that edge.
- Register map (offset = adr[5:2], word index; each 64-bit register is split LO = pins 31:0, HI = pins 63:32):
  - 0 OUT_LO, 1 OUT_HI: RW
  - 2 OEB_LO, 3 OEB_HI: RW
  - 4 IN_LO, 5 IN_HI: RO
  - 6 RISE_EN_LO, 7 RISE_EN_HI: RW
  - 8 FALL_EN_LO, 9 FALL_EN_HI: RW
  - 10 STAT_LO, 11 STAT_HI: W1C
  - 12 ID: RO
  - 13-15: unmapped; read 0, writes ignored.
- Bits at or above NUM_GPIO, and bits set in RESERVED_MASK, read 0 in every register and ignore writes.
- Handshake:
  - A request is stb&cyc&window-hit&~ack.
  - wbs_ack_o rises on the edge after the request and stays high exactly one cycle.
  - A held strobe therefore gives back-to-back acks every 2 cycles.
  - Out-of-window address: no ack, wbs_dat_o held 0.
- Writes commit on the same edge that raises ack. Only bytes with wbs_sel_i[k]=1 are written. For STAT, a 1 in a selected byte clears that bit.
- Reads: wbs_dat_o is registered with ack and returns to 0 the cycle after ack. wbs_sel_i is ignored on reads.
- Pad outputs: gpio_out=OUT, gpio_oeb=OEB, both registered. Reserved pins are forced out=0, oeb=1.
- Input path:
  - 2-flop synchroniser feeds sync, then one prev flop.
  - IN reflects sync; a pad change is visible 2 edges later.
  - rise = sync&~prev&RISE_EN; fall = ~sync&prev&FALL_EN.
  - STAT bit sets on the edge after rise or fall is detected (3rd edge after the pad change).
  - If a W1C clear and a new edge hit the same bit on the same cycle, set wins.
- irq is registered as |STAT and goes low one edge after the last status bit clears.
- Disabling RISE_EN or FALL_EN does not clear existing STAT bits.

Test Plan:
- Reset, then read OEB_LO/OEB_HI/OUT_LO/ID -> 0xFFFF_FFE1 / 0x0000_003F / 0 / 0x0000_0707. Each ack lasts 1 cycle, 1 cycle after stb.
- Write OUT_LO=0xFFFF_FFFF with sel=4'b0001, OEB_LO=0 -> gpio_out[7:0]=0xE1, gpio_out[31:8]=0, gpio_oeb[4:1]=4'hF, gpio_oeb[0]=0.
- Set RISE_EN_LO=0x20, drive gpio_in[5] 0->1 -> IN_LO bit5=1 after 2 edges, STAT_LO=0x20 and irq=1 by the 4th edge. Write STAT_LO=0x20 -> irq=0 one edge later.
- Set FALL_EN_HI=0x1; on the same cycle that the STAT_HI W1C of bit0 commits, a gpio_in[32] falling edge is detected -> STAT_HI bit0 remains 1.
- Access adr 0x3000_0040 -> no ack within 4 cycles. Read offset 0x34 -> ack, data 0.
- Hold stb/cyc high for 6 cycles on a read -> acks on cycles 2, 4 and 6. Assert wb_rst_i on cycle 3 -> no ack on cycle 4, all outputs at reset values.

Source files
------------

// File: rtl/team_wb_gpio_bridge.sv
// Wishbone-slave GPIO controller: output data, active-low enables, synchronised
// inputs, sticky W1C edge status with a level interrupt, and hard-reserved pins.
module team_wb_gpio_bridge #(
    parameter int          NUM_GPIO      = 38,
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter logic [63:0] RESERVED_MASK = 64'h0000_0000_0000_001E,
    parameter logic [31:0] ID_VALUE      = 32'h0000_0707
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_dat_i,
    input  logic [31:0]         wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oeb,
    output logic                irq
);

    function automatic logic [63:0] valid_mask_f(input int n, input logic [63:0] res);
        logic [63:0] m;
        if (n >= 64) begin
            m = {64{1'b1}};
        end else begin
            m = (64'd1 << n) - 64'd1;
        end
        return m & ~res;
    endfunction

    function automatic logic [31:0] lane_mask_f(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] merge_f(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] lanes);
        return (old_v & ~lanes) | (new_v & lanes);
    endfunction

    // Pins that exist and are not reserved; every other bit reads 0 everywhere.
    localparam logic [63:0] VALID_MASK = valid_mask_f(NUM_GPIO, RESERVED_MASK);

    logic [63:0] out_q, out_d;
    logic [63:0] oeb_q, oeb_d;
    logic [63:0] rise_en_q, rise_en_d;
    logic [63:0] fall_en_q, fall_en_d;
    logic [63:0] stat_q, stat_d;
    logic [63:0] sync1_q, sync1_d;
    logic [63:0] sync2_q, sync2_d;
    logic [63:0] prev_q, prev_d;
    logic        ack_q, ack_d;
    logic        irq_q, irq_d;
    logic [31:0] dat_q, dat_d;

    logic [63:0] gpio_in_ext_s;
    logic [63:0] clr_s;
    logic [63:0] rise_s;
    logic [63:0] fall_s;
    logic        hit_s;
    logic        req_s;
    logic        wr_s;
    logic        rd_s;
    logic [3:0]  off_s;
    logic [31:0] lanes_s;
    logic [31:0] rd_data_s;
    logic        unused_s;

    assign unused_s = ^wbs_adr_i[1:0];

    // Bus request decode; a request is never taken while its ack is showing.
    always_comb begin
        hit_s   = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
        req_s   = wbs_stb_i & wbs_cyc_i & hit_s & ~ack_q;
        wr_s    = req_s & wbs_we_i;
        rd_s    = req_s & ~wbs_we_i;
        off_s   = wbs_adr_i[5:2];
        lanes_s = lane_mask_f(wbs_sel_i);
    end

    // Zero-extend the pad inputs to the full 64-bit register width.
    always_comb begin
        gpio_in_ext_s                 = 64'd0;
        gpio_in_ext_s[NUM_GPIO-1:0]   = gpio_in;
    end

    // Read data mux; OEB stores 1s on hidden pins so it is masked on the way out.
    always_comb begin
        case (off_s)
            4'd0:    rd_data_s = out_q[31:0];
            4'd1:    rd_data_s = out_q[63:32];
            4'd2:    rd_data_s = oeb_q[31:0] & VALID_MASK[31:0];
            4'd3:    rd_data_s = oeb_q[63:32] & VALID_MASK[63:32];
            4'd4:    rd_data_s = sync2_q[31:0] & VALID_MASK[31:0];
            4'd5:    rd_data_s = sync2_q[63:32] & VALID_MASK[63:32];
            4'd6:    rd_data_s = rise_en_q[31:0];
            4'd7:    rd_data_s = rise_en_q[63:32];
            4'd8:    rd_data_s = fall_en_q[31:0];
            4'd9:    rd_data_s = fall_en_q[63:32];
            4'd10:   rd_data_s = stat_q[31:0];
            4'd11:   rd_data_s = stat_q[63:32];
            4'd12:   rd_data_s = ID_VALUE;
            default: rd_data_s = 32'd0;
        endcase
    end

    // Next-state: register writes, input pipeline, edge status and bus response.
    always_comb begin
        out_d     = out_q;
        oeb_d     = oeb_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr_s     = 64'd0;
        if (wr_s) begin
            case (off_s)
                4'd0:    out_d[31:0]      = merge_f(out_q[31:0], wbs_dat_i, lanes_s);
                4'd1:    out_d[63:32]     = merge_f(out_q[63:32], wbs_dat_i, lanes_s);
                4'd2:    oeb_d[31:0]      = merge_f(oeb_q[31:0], wbs_dat_i, lanes_s);
                4'd3:    oeb_d[63:32]     = merge_f(oeb_q[63:32], wbs_dat_i, lanes_s);
                4'd6:    rise_en_d[31:0]  = merge_f(rise_en_q[31:0], wbs_dat_i, lanes_s);
                4'd7:    rise_en_d[63:32] = merge_f(rise_en_q[63:32], wbs_dat_i, lanes_s);
                4'd8:    fall_en_d[31:0]  = merge_f(fall_en_q[31:0], wbs_dat_i, lanes_s);
                4'd9:    fall_en_d[63:32] = merge_f(fall_en_q[63:32], wbs_dat_i, lanes_s);
                4'd10:   clr_s[31:0]      = wbs_dat_i & lanes_s;
                4'd11:   clr_s[63:32]     = wbs_dat_i & lanes_s;
                default: clr_s            = 64'd0;
            endcase
        end else begin
            clr_s = 64'd0;
        end
        out_d     = out_d & VALID_MASK;
        oeb_d     = oeb_d | ~VALID_MASK;
        rise_en_d = rise_en_d & VALID_MASK;
        fall_en_d = fall_en_d & VALID_MASK;

        // New edges are ORed in after the clear so a same-cycle set wins.
        rise_s = sync2_q & ~prev_q & rise_en_q;
        fall_s = ~sync2_q & prev_q & fall_en_q;
        stat_d = ((stat_q & ~clr_s) | rise_s | fall_s) & VALID_MASK;

        sync1_d = gpio_in_ext_s;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        ack_d = req_s;
        if (rd_s) begin
            dat_d = rd_data_s;
        end else begin
            dat_d = 32'd0;
        end
        irq_d = |stat_q;
    end

    // State registers with synchronous reset; reset also discards an in-flight write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= 64'd0;
            oeb_q     <= {64{1'b1}};
            rise_en_q <= 64'd0;
            fall_en_q <= 64'd0;
            stat_q    <= 64'd0;
            sync1_q   <= 64'd0;
            sync2_q   <= 64'd0;
            prev_q    <= 64'd0;
            ack_q     <= 1'b0;
            irq_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            out_q     <= out_d;
            oeb_q     <= oeb_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            ack_q     <= ack_d;
            irq_q     <= irq_d;
            dat_q     <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign gpio_out  = out_q[NUM_GPIO-1:0];
    assign gpio_oeb  = oeb_q[NUM_GPIO-1:0];
    assign irq       = irq_q;

endmodule

// File: tb/tb_team_wb_gpio_bridge.sv
// Self-checking bench for team_wb_gpio_bridge: vector table, timing sequences
// and a randomized phase against a register-level reference model.
module tb_team_wb_gpio_bridge;

    localparam int          NUM_GPIO = 38;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [63:0] RES      = 64'h0000_0000_0000_001E;
    localparam logic [31:0] ID       = 32'h0000_0707;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i;
    logic                wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]          wbs_sel_i;
    logic [31:0]         wbs_dat_i, wbs_adr_i;
    logic                wbs_ack_o;
    logic [31:0]         wbs_dat_o;
    logic [NUM_GPIO-1:0] gpio_in, gpio_out, gpio_oeb;
    logic                irq;

    team_wb_gpio_bridge #(
        .NUM_GPIO(NUM_GPIO), .BASE_ADDR(BASE), .RESERVED_MASK(RES), .ID_VALUE(ID)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain register words, pad image and sticky status.
    logic [63:0] valid, pinmask;
    logic [31:0] ref_reg [16];
    logic [63:0] ref_stat, ref_in;

    typedef struct {
        logic        we;
        logic [3:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] vmask(input logic [3:0] off);
        return off[0] ? valid[63:32] : valid[31:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_reg[i] = 32'd0;
        ref_reg[2] = 32'hFFFF_FFFF;
        ref_reg[3] = 32'hFFFF_FFFF;
        ref_stat   = 64'd0;
    endtask

    task automatic model_write(input logic [3:0] off, input logic [3:0] sel, input logic [31:0] dat);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                if (off inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9})
                    ref_reg[off][8*b +: 8] = dat[8*b +: 8];
                else if (off == 4'd10)
                    ref_stat[8*b +: 8] = ref_stat[8*b +: 8] & ~dat[8*b +: 8];
                else if (off == 4'd11)
                    ref_stat[32+8*b +: 8] = ref_stat[32+8*b +: 8] & ~dat[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] off);
        case (off)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9: return ref_reg[off] & vmask(off);
            4'd4:  return ref_in[31:0] & valid[31:0];
            4'd5:  return ref_in[63:32] & valid[63:32];
            4'd10: return ref_stat[31:0];
            4'd11: return ref_stat[63:32];
            4'd12: return ID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_input_change(input logic [63:0] new_in);
        logic [63:0] ren, fen;
        ren = {ref_reg[7], ref_reg[6]} & valid;
        fen = {ref_reg[9], ref_reg[8]} & valid;
        ref_stat = ref_stat | (new_in & ~ref_in & ren) | (~new_in & ref_in & fen);
        ref_in   = new_in;
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    // Called at a negedge; returns at a negedge one cycle after the ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] dat, output logic [31:0] rdata,
                             output logic acked, output logic irq_at_ack);
        int lat;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        acked = 1'b0; rdata = 32'd0; irq_at_ack = 1'b0; lat = 0;
        for (int c = 1; c <= 4 && !acked; c++) begin
            tick();
            if (wbs_ack_o) begin
                acked = 1'b1; rdata = wbs_dat_o; irq_at_ack = irq; lat = c;
            end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        if (acked) begin
            check("ack_latency", 64'(lat), 64'd1);
            tick();
            check("ack_width", {63'd0, wbs_ack_o}, 64'd0);
            check("dat_clear", {32'd0, wbs_dat_o}, 64'd0);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] rd;
        logic ok, ia;
        wb_access(1'b1, BASE + {26'd0, off, 2'b00}, sel, dat, rd, ok, ia);
        check("write_ack", {63'd0, ok}, 64'd1);
        model_write(off, sel, dat);
    endtask

    task automatic bus_read(input logic [3:0] off, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        logic ok, ia;
        wb_access(1'b0, BASE + {26'd0, off, 2'b00}, 4'hF, 32'd0, rd, ok, ia);
        check({name, "_ack"}, {63'd0, ok}, 64'd1);
        check(name, {32'd0, rd}, {32'd0, exp});
    endtask

    initial begin
        logic [31:0] rd;
        logic        ok, ia;
        logic [63:0] nv;

        for (int i = 0; i < 64; i++) begin
            pinmask[i] = (i < NUM_GPIO);
            valid[i]   = (i < NUM_GPIO) && !RES[i];
        end
        vecs[0]  = '{1'b0, 4'd2,  4'hF, 32'd0,         32'hFFFF_FFE1};
        vecs[1]  = '{1'b0, 4'd3,  4'hF, 32'd0,         32'h0000_003F};
        vecs[2]  = '{1'b0, 4'd0,  4'hF, 32'd0,         32'h0000_0000};
        vecs[3]  = '{1'b0, 4'd12, 4'hF, 32'd0,         32'h0000_0707};
        vecs[4]  = '{1'b1, 4'd0,  4'h1, 32'hFFFF_FFFF, 32'd0};
        vecs[5]  = '{1'b1, 4'd2,  4'hF, 32'h0000_0000, 32'd0};
        vecs[6]  = '{1'b0, 4'd0,  4'hF, 32'd0,         32'h0000_00E1};
        vecs[7]  = '{1'b0, 4'd2,  4'hF, 32'd0,         32'h0000_0000};
        vecs[8]  = '{1'b1, 4'd13, 4'hF, 32'hFFFF_FFFF, 32'd0};
        vecs[9]  = '{1'b0, 4'd13, 4'hF, 32'd0,         32'h0000_0000};
        vecs[10] = '{1'b1, 4'd1,  4'hF, 32'hFFFF_FFFF, 32'd0};
        vecs[11] = '{1'b0, 4'd1,  4'hF, 32'd0,         32'h0000_003F};
        vecs[12] = '{1'b1, 4'd12, 4'hF, 32'h0000_0000, 32'd0};
        vecs[13] = '{1'b0, 4'd12, 4'hF, 32'd0,         32'h0000_0707};
        vecs[14] = '{1'b0, 4'd5,  4'hF, 32'd0,         32'h0000_0001};

        wb_rst_i = 1'b1; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'd0; wbs_adr_i = 32'd0;
        gpio_in = '0;
        gpio_in[32] = 1'b1;
        ref_in = 64'd0;
        ref_in[32] = 1'b1;
        model_reset();

        // Reset state of every output.
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_ack", {63'd0, wbs_ack_o}, 64'd0);
        check("rst_dat", {32'd0, wbs_dat_o}, 64'd0);
        check("rst_irq", {63'd0, irq}, 64'd0);
        check("rst_out", 64'(gpio_out), 64'd0);
        check("rst_oeb", 64'(gpio_oeb), pinmask);
        wb_rst_i = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].we) bus_write(vecs[i].off, vecs[i].sel, vecs[i].wdat);
            else            bus_read(vecs[i].off, vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("pad_out_7_0", {56'd0, gpio_out[7:0]}, 64'hE1);
        check("pad_out_31_8", {40'd0, gpio_out[31:8]}, 64'd0);
        check("pad_out_37_32", {58'd0, gpio_out[37:32]}, 64'h3F);
        check("pad_oeb_4_1", {60'd0, gpio_oeb[4:1]}, 64'hF);
        check("pad_oeb_0", {63'd0, gpio_oeb[0]}, 64'd0);
        check("pad_oeb_31_5", {37'd0, gpio_oeb[31:5]}, 64'd0);

        // Rising edge on pin 5: status on the 3rd edge, irq on the 4th.
        bus_write(4'd6, 4'hF, 32'h20);
        gpio_in[5] = 1'b1;
        model_input_change(ref_in | 64'h20);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rise_irq_e%0d", k), {63'd0, irq}, {63'd0, (k == 4)});
        end
        bus_read(4'd4, 32'h20, "in_lo_rise");
        bus_read(4'd10, 32'h20, "stat_lo_rise");

        // Synchroniser latency: request sampled on the 2nd edge still sees the old value.
        gpio_in[6] = 1'b1;
        tick();
        bus_read(4'd4, 32'h20, "in_lat_early");
        model_input_change(ref_in | 64'h40);
        bus_read(4'd4, 32'h60, "in_lat_late");

        // W1C clear: irq still high at the ack, low one edge later.
        wb_access(1'b1, BASE + 32'h28, 4'hF, 32'h20, rd, ok, ia);
        model_write(4'd10, 4'hF, 32'h20);
        check("w1c_ack", {63'd0, ok}, 64'd1);
        check("w1c_irq_at_ack", {63'd0, ia}, 64'd1);
        check("w1c_irq_after", {63'd0, irq}, 64'd0);
        bus_read(4'd10, 32'h0, "stat_lo_cleared");

        // Set beats clear when a fall on pin 32 and its W1C land on the same edge.
        bus_write(4'd9, 4'hF, 32'h1);
        gpio_in[32] = 1'b0;
        tick();
        tick();
        wb_access(1'b1, BASE + 32'h2C, 4'hF, 32'h1, rd, ok, ia);
        check("set_wins_ack", {63'd0, ok}, 64'd1);
        model_write(4'd11, 4'hF, 32'h1);
        model_input_change(ref_in & ~(64'd1 << 32));
        bus_read(4'd11, 32'h1, "set_wins_stat");
        check("set_wins_irq", {63'd0, irq}, 64'd1);

        // Out-of-window accesses: no ack, no data, no write side effect.
        wb_access(1'b0, 32'h3000_0040, 4'hF, 32'd0, rd, ok, ia);
        check("oow_rd_noack", {63'd0, ok}, 64'd0);
        check("oow_dat", {32'd0, wbs_dat_o}, 64'd0);
        wb_access(1'b1, 32'h3000_0040, 4'hF, 32'd0, rd, ok, ia);
        check("oow_wr_noack", {63'd0, ok}, 64'd0);
        tick();
        bus_read(4'd0, 32'hE1, "oow_no_commit");

        // Held strobe: acks every other cycle.
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = BASE;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("held_ack_c%0d", k), {63'd0, wbs_ack_o}, {63'd0, (k % 2 == 1)});
            if (k % 2 == 1) check($sformatf("held_dat_c%0d", k), {32'd0, wbs_dat_o}, {32'd0, model_read(4'd0)});
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        tick();

        // Reset during a held strobe suppresses the next ack and clears everything.
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        tick();
        check("hr_ack1", {63'd0, wbs_ack_o}, 64'd1);
        tick();
        check("hr_gap", {63'd0, wbs_ack_o}, 64'd0);
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        model_reset();
        check("hr_rst_ack", {63'd0, wbs_ack_o}, 64'd0);
        check("hr_rst_dat", {32'd0, wbs_dat_o}, 64'd0);
        check("hr_rst_irq", {63'd0, irq}, 64'd0);
        check("hr_rst_out", 64'(gpio_out), 64'd0);
        check("hr_rst_oeb", 64'(gpio_oeb), pinmask);
        tick();
        check("hr_ack_after", {63'd0, wbs_ack_o}, 64'd1);
        check("hr_dat_after", {32'd0, wbs_dat_o}, 64'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        repeat (4) tick();

        // Randomized register traffic and pad activity against the model.
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                nv = {$urandom, $urandom} & pinmask;
                gpio_in = nv[NUM_GPIO-1:0];
                model_input_change(nv);
                repeat (4) tick();
                check("rnd_irq", {63'd0, irq}, {63'd0, (ref_stat != 64'd0)});
            end else begin
                logic [3:0] off;
                off = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) bus_write(off, 4'($urandom), $urandom);
                else bus_read(off, model_read(off), $sformatf("rnd_rd_off%0d", off));
            end
        end
        check("rnd_pad_out", 64'(gpio_out), {ref_reg[1], ref_reg[0]} & valid);
        check("rnd_pad_oeb", 64'(gpio_oeb), ({ref_reg[3], ref_reg[2]} | ~valid) & pinmask);
        check("rnd_final_irq", {63'd0, irq}, {63'd0, (ref_stat != 64'd0)});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
